fpu_mds_seq: RTL and testbench

FPU_MDS_SEQ -- requirements
Module: fpu_mds_seq

---
 rtl/fpu_mds_pkg.sv | 32 +++
 rtl/fpu_mds_classify.sv | 35 +++
 rtl/fpu_mds_seq.sv | 201 ++++++++++++++++++++
 tb/tb_fpu_mds_seq.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_mds_pkg.sv
// rtl/fpu_mds_pkg.sv - shared codes, state encoding and NaN helper for the FPU sequencer
package fpu_mds_pkg;

    localparam logic [1:0] OP_FMUL  = 2'b00;
    localparam logic [1:0] OP_FDIV  = 2'b01;
    localparam logic [1:0] OP_FSQRT = 2'b10;
    localparam logic [1:0] OP_ILL   = 2'b11;

    localparam logic [1:0] RS_MUL  = 2'b00;
    localparam logic [1:0] RS_DIV  = 2'b01;
    localparam logic [1:0] RS_SQRT = 2'b10;
    localparam logic [1:0] RS_FAST = 2'b11;

    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_MUL       = 3'd1,
        ST_DIV_WAIT  = 3'd2,
        ST_SQRT_WAIT = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    // Canonical quiet NaN, zero-extended to 64 bits; callers slice to their word width.
    function automatic logic [63:0] canon_qnan(input int exp_w, input int man_w);
        logic [63:0] r;
        r = ((64'd1 << exp_w) - 64'd1) << man_w;
        r = r | (64'd1 << (man_w - 1));
        return r;
    endfunction

endpackage

// File: rtl/fpu_mds_classify.sv
// rtl/fpu_mds_classify.sv - classifies one IEEE operand into zero/inf/qNaN/sNaN plus sign
module fpu_mds_classify
    import fpu_mds_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [EXP_W+MAN_W:0] op,
    output logic                 is_zero,
    output logic                 is_inf,
    output logic                 is_qnan,
    output logic                 is_snan,
    output logic                 sign
);

    logic [EXP_W-1:0] exp_f;
    logic [MAN_W-1:0] man_f;
    logic             exp_ones;
    logic             exp_zero;
    logic             man_zero;

    assign sign     = op[EXP_W+MAN_W];
    assign exp_f    = op[EXP_W+MAN_W-1:MAN_W];
    assign man_f    = op[MAN_W-1:0];
    assign exp_ones = &exp_f;
    assign exp_zero = ~|exp_f;
    assign man_zero = ~|man_f;

    // Subnormals (zero exponent, nonzero mantissa) fall through as finite-nonzero.
    assign is_zero = exp_zero & man_zero;
    assign is_inf  = exp_ones & man_zero;
    assign is_qnan = exp_ones & man_f[MAN_W-1];
    assign is_snan = exp_ones & ~man_f[MAN_W-1] & ~man_zero;

endmodule

// File: rtl/fpu_mds_seq.sv
// rtl/fpu_mds_seq.sv - FMUL/FDIV/FSQRT sequencer with special-case fast path
module fpu_mds_seq
    import fpu_mds_pkg::*;
#(
    parameter int EXP_W   = 8,
    parameter int MAN_W   = 23,
    parameter int MUL_LAT = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           op_sel,
    input  logic [EXP_W+MAN_W:0] opa,
    input  logic [EXP_W+MAN_W:0] opb,
    input  logic                 kill,
    input  logic                 div_rdy,
    input  logic                 sqrt_rdy,
    input  logic                 res_ready,
    output logic                 div_start,
    output logic                 sqrt_start,
    output logic                 reg_en,
    output logic [1:0]           res_sel,
    output logic [EXP_W+MAN_W:0] fast_res,
    output logic                 nv_fast,
    output logic                 dz_fast,
    output logic                 res_valid,
    output logic                 busy
);

    localparam int W = 1 + EXP_W + MAN_W;
    localparam logic [63:0]      QNAN_FULL = canon_qnan(EXP_W, MAN_W);
    localparam logic [W-1:0]     QNAN      = QNAN_FULL[W-1:0];
    localparam logic [CNT_W-1:0] MUL_LOAD  = CNT_W'(MUL_LAT - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic a_zero, a_inf, a_qnan, a_snan, a_sign;
    logic b_zero, b_inf, b_qnan, b_snan, b_sign;
    logic a_nan, b_nan, sgn;
    logic [W-1:0] inf_w, zero_w;
    logic         special, f_nv, f_dz;
    logic [W-1:0] f_res;
    logic         act;

    fpu_mds_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
        .op(opa), .is_zero(a_zero), .is_inf(a_inf), .is_qnan(a_qnan), .is_snan(a_snan), .sign(a_sign)
    );

    fpu_mds_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
        .op(opb), .is_zero(b_zero), .is_inf(b_inf), .is_qnan(b_qnan), .is_snan(b_snan), .sign(b_sign)
    );

    assign a_nan  = a_qnan | a_snan;
    assign b_nan  = b_qnan | b_snan;
    assign sgn    = a_sign ^ b_sign;
    assign inf_w  = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    assign zero_w = {sgn, {(W-1){1'b0}}};

    always_comb begin
        special = 1'b0;
        f_res   = '0;
        f_nv    = 1'b0;
        f_dz    = 1'b0;
        case (op_sel)
            OP_FMUL: begin
                if (a_nan || b_nan) begin
                    special = 1'b1; f_res = QNAN; f_nv = a_snan | b_snan;
                end else if ((a_zero && b_inf) || (a_inf && b_zero)) begin
                    special = 1'b1; f_res = QNAN; f_nv = 1'b1;
                end else if (a_inf || b_inf) begin
                    special = 1'b1; f_res = inf_w;
                end else if (a_zero || b_zero) begin
                    special = 1'b1; f_res = zero_w;
                end
            end
            OP_FDIV: begin
                if (a_nan || b_nan) begin
                    special = 1'b1; f_res = QNAN; f_nv = a_snan | b_snan;
                end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
                    special = 1'b1; f_res = QNAN; f_nv = 1'b1;
                end else if (a_inf) begin
                    special = 1'b1; f_res = inf_w;
                end else if (b_zero) begin
                    special = 1'b1; f_res = inf_w; f_dz = 1'b1;
                end else if (a_zero || b_inf) begin
                    special = 1'b1; f_res = zero_w;
                end
            end
            OP_FSQRT: begin
                if (a_nan) begin
                    special = 1'b1; f_res = QNAN; f_nv = a_snan;
                end else if (a_zero) begin
                    special = 1'b1; f_res = {a_sign, {(W-1){1'b0}}};
                end else if (a_sign) begin
                    special = 1'b1; f_res = QNAN; f_nv = 1'b1;
                end else if (a_inf) begin
                    special = 1'b1; f_res = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                end
            end
            default: begin
                special = 1'b1; f_res = QNAN; f_nv = 1'b1;
            end
        endcase
    end

    // Handshake strobes react to rdy/kill within the same cycle, so they stay combinational.
    assign act        = ~reset & ~kill;
    assign div_start  = act & (state == ST_DIV_WAIT) & ~div_rdy;
    assign sqrt_start = act & (state == ST_SQRT_WAIT) & ~sqrt_rdy;
    assign reg_en     = act & (((state == ST_IDLE) & start & special) |
                               ((state == ST_MUL) & (cnt == '0)) |
                               ((state == ST_DIV_WAIT) & div_rdy) |
                               ((state == ST_SQRT_WAIT) & sqrt_rdy));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            fast_res  <= '0;
            nv_fast   <= 1'b0;
            dz_fast   <= 1'b0;
            res_sel   <= RS_MUL;
            res_valid <= 1'b0;
            busy      <= 1'b0;
        end else if (kill) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            res_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (special) begin
                            fast_res  <= f_res;
                            nv_fast   <= f_nv;
                            dz_fast   <= f_dz;
                            res_sel   <= RS_FAST;
                            res_valid <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            fast_res <= '0;
                            nv_fast  <= 1'b0;
                            dz_fast  <= 1'b0;
                            case (op_sel)
                                OP_FDIV: begin
                                    state   <= ST_DIV_WAIT;
                                    res_sel <= RS_DIV;
                                end
                                OP_FSQRT: begin
                                    state   <= ST_SQRT_WAIT;
                                    res_sel <= RS_SQRT;
                                end
                                default: begin
                                    state   <= ST_MUL;
                                    res_sel <= RS_MUL;
                                    cnt     <= MUL_LOAD;
                                end
                            endcase
                        end
                    end
                end
                ST_MUL: begin
                    if (cnt == '0) begin
                        state     <= ST_DONE;
                        res_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DIV_WAIT: begin
                    if (div_rdy) begin
                        state     <= ST_DONE;
                        res_valid <= 1'b1;
                    end
                end
                ST_SQRT_WAIT: begin
                    if (sqrt_rdy) begin
                        state     <= ST_DONE;
                        res_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (res_ready) begin
                        state     <= ST_IDLE;
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    res_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_mds_seq.sv
// tb/tb_fpu_mds_seq.sv - directed vector bench for fpu_mds_seq
module tb_fpu_mds_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op_sel;
    logic [31:0] opa, opb;
    logic        kill, div_rdy, sqrt_rdy, res_ready;
    logic        div_start, sqrt_start, reg_en;
    logic [1:0]  res_sel;
    logic [31:0] fast_res;
    logic        nv_fast, dz_fast, res_valid, busy;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fpu_mds_seq #(.EXP_W(8), .MAN_W(23), .MUL_LAT(2)) dut (
        .clk(clk), .reset(reset), .start(start), .op_sel(op_sel),
        .opa(opa), .opb(opb), .kill(kill), .div_rdy(div_rdy),
        .sqrt_rdy(sqrt_rdy), .res_ready(res_ready), .div_start(div_start),
        .sqrt_start(sqrt_start), .reg_en(reg_en), .res_sel(res_sel),
        .fast_res(fast_res), .nv_fast(nv_fast), .dz_fast(dz_fast),
        .res_valid(res_valid), .busy(busy)
    );

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        nv;
        logic        dz;
    } fvec_t;

    fvec_t tv[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        tv.push_back('{2'b00, 32'h00000000, 32'hFF800000, 32'h7FC00000, 1'b1, 1'b0});
        tv.push_back('{2'b01, 32'h3F800000, 32'h80000000, 32'hFF800000, 1'b0, 1'b1});
        tv.push_back('{2'b10, 32'h7F800001, 32'h00000000, 32'h7FC00000, 1'b1, 1'b0});
        tv.push_back('{2'b00, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b0});
        tv.push_back('{2'b00, 32'h7F800001, 32'h3F800000, 32'h7FC00000, 1'b1, 1'b0});
        tv.push_back('{2'b01, 32'h00000000, 32'h80000000, 32'h7FC00000, 1'b1, 1'b0});
        tv.push_back('{2'b01, 32'hFF800000, 32'h7F800000, 32'h7FC00000, 1'b1, 1'b0});
        tv.push_back('{2'b01, 32'hBF800000, 32'h7F800000, 32'h80000000, 1'b0, 1'b0});
        tv.push_back('{2'b00, 32'h80000000, 32'h3F800000, 32'h80000000, 1'b0, 1'b0});
        tv.push_back('{2'b00, 32'hFF800000, 32'hBF800000, 32'h7F800000, 1'b0, 1'b0});
        tv.push_back('{2'b10, 32'h80000000, 32'h12345678, 32'h80000000, 1'b0, 1'b0});
        tv.push_back('{2'b10, 32'h7F800000, 32'h00000000, 32'h7F800000, 1'b0, 1'b0});
        tv.push_back('{2'b10, 32'hFF800000, 32'h00000000, 32'h7FC00000, 1'b1, 1'b0});
        tv.push_back('{2'b10, 32'hBF800000, 32'h00000000, 32'h7FC00000, 1'b1, 1'b0});
        tv.push_back('{2'b01, 32'h7F800000, 32'h00000000, 32'h7F800000, 1'b0, 1'b0});
        tv.push_back('{2'b01, 32'h00000001, 32'h80000000, 32'hFF800000, 1'b0, 1'b1});
        tv.push_back('{2'b00, 32'h00000001, 32'h00000000, 32'h00000000, 1'b0, 1'b0});
        tv.push_back('{2'b01, 32'h80000000, 32'h3F800000, 32'h80000000, 1'b0, 1'b0});
        tv.push_back('{2'b11, 32'h3F800000, 32'h3F800000, 32'h7FC00000, 1'b1, 1'b0});

        reset = 1'b1; start = 1'b1; op_sel = 2'b11; opa = 32'h3F800000; opb = 32'h3F800000;
        kill = 1'b0; div_rdy = 1'b0; sqrt_rdy = 1'b0; res_ready = 1'b0;
        #1;
        smp();
        chk("rst reg_en", 32'(reg_en), 32'd0);
        chk("rst res_valid", 32'(res_valid), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst fast_res", fast_res, 32'h0);
        chk("rst res_sel", 32'(res_sel), 32'd0);
        cyc();
        start = 1'b0;
        reset = 1'b0;

        for (int i = 0; i < tv.size(); i++) begin
            start = 1'b1; op_sel = tv[i].op; opa = tv[i].a; opb = tv[i].b;
            smp();
            chk($sformatf("v%0d c0 reg_en", i), 32'(reg_en), 32'd1);
            chk($sformatf("v%0d c0 busy", i), 32'(busy), 32'd0);
            cyc();
            start = 1'b0;
            smp();
            chk($sformatf("v%0d res_valid", i), 32'(res_valid), 32'd1);
            chk($sformatf("v%0d res_sel", i), 32'(res_sel), 32'd3);
            chk($sformatf("v%0d fast_res", i), fast_res, tv[i].res);
            chk($sformatf("v%0d nv", i), 32'(nv_fast), 32'(tv[i].nv));
            chk($sformatf("v%0d dz", i), 32'(dz_fast), 32'(tv[i].dz));
            res_ready = 1'b1;
            cyc();
            res_ready = 1'b0;
            smp();
            chk($sformatf("v%0d idle busy", i), 32'(busy), 32'd0);
            cyc();
        end

        // FMUL normal path; a second start during MUL must be ignored
        start = 1'b1; op_sel = 2'b00; opa = 32'h3F800000; opb = 32'h40000000;
        smp();
        chk("mul c0 reg_en", 32'(reg_en), 32'd0);
        cyc();
        op_sel = 2'b11;
        smp();
        chk("mul c1 busy", 32'(busy), 32'd1);
        chk("mul c1 reg_en", 32'(reg_en), 32'd0);
        chk("mul c1 res_valid", 32'(res_valid), 32'd0);
        cyc();
        start = 1'b0;
        smp();
        chk("mul c2 reg_en", 32'(reg_en), 32'd1);
        chk("mul c2 res_valid", 32'(res_valid), 32'd0);
        cyc();
        smp();
        chk("mul c3 res_valid", 32'(res_valid), 32'd1);
        chk("mul c3 res_sel", 32'(res_sel), 32'd0);
        chk("mul c3 nv", 32'(nv_fast), 32'd0);
        chk("mul c3 dz", 32'(dz_fast), 32'd0);
        res_ready = 1'b1;
        cyc();
        res_ready = 1'b0;
        smp();
        chk("mul idle busy", 32'(busy), 32'd0);
        chk("mul idle res_valid", 32'(res_valid), 32'd0);
        cyc();

        // FDIV normal, div_rdy at cycle 10, res_ready held low 3 cycles
        start = 1'b1; op_sel = 2'b01; opa = 32'h3F800000; opb = 32'h40000000;
        smp();
        chk("div c0 div_start", 32'(div_start), 32'd0);
        cyc();
        start = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            smp();
            chk($sformatf("div c%0d div_start", c), 32'(div_start), 32'd1);
            cyc();
        end
        div_rdy = 1'b1;
        smp();
        chk("div c10 div_start", 32'(div_start), 32'd0);
        chk("div c10 reg_en", 32'(reg_en), 32'd1);
        cyc();
        div_rdy = 1'b0;
        for (int c = 11; c <= 14; c++) begin
            res_ready = (c == 14);
            smp();
            chk($sformatf("div c%0d res_valid", c), 32'(res_valid), 32'd1);
            chk($sformatf("div c%0d res_sel", c), 32'(res_sel), 32'd1);
            cyc();
        end
        res_ready = 1'b0;
        smp();
        chk("div idle busy", 32'(busy), 32'd0);
        chk("div idle res_valid", 32'(res_valid), 32'd0);
        cyc();

        // FSQRT normal, killed at cycle 4
        start = 1'b1; op_sel = 2'b10; opa = 32'h40800000; opb = 32'h0;
        smp();
        cyc();
        start = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            smp();
            chk($sformatf("sqrt c%0d sqrt_start", c), 32'(sqrt_start), 32'd1);
            cyc();
        end
        kill = 1'b1;
        smp();
        chk("kill c4 sqrt_start", 32'(sqrt_start), 32'd0);
        chk("kill c4 reg_en", 32'(reg_en), 32'd0);
        chk("kill c4 busy", 32'(busy), 32'd1);
        cyc();
        kill = 1'b0;
        smp();
        chk("kill c5 busy", 32'(busy), 32'd0);
        chk("kill c5 res_valid", 32'(res_valid), 32'd0);
        cyc();
        smp();
        chk("kill c6 res_valid", 32'(res_valid), 32'd0);
        cyc();

        // kill beats start in IDLE
        start = 1'b1; kill = 1'b1; op_sel = 2'b11;
        smp();
        chk("kill idle reg_en", 32'(reg_en), 32'd0);
        cyc();
        start = 1'b0; kill = 1'b0;
        smp();
        chk("kill idle busy", 32'(busy), 32'd0);
        chk("kill idle res_valid", 32'(res_valid), 32'd0);
        cyc();

        // sNaN sqrt, then async reset while in DONE
        start = 1'b1; op_sel = 2'b10; opa = 32'h7F800001; opb = 32'h0;
        smp();
        cyc();
        start = 1'b0;
        smp();
        chk("snan sqrt res_valid", 32'(res_valid), 32'd1);
        chk("snan sqrt fast_res", fast_res, 32'h7FC00000);
        chk("snan sqrt nv", 32'(nv_fast), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst res_valid", 32'(res_valid), 32'd0);
        chk("arst busy", 32'(busy), 32'd0);
        chk("arst fast_res", fast_res, 32'h0);
        chk("arst nv", 32'(nv_fast), 32'd0);
        chk("arst res_sel", 32'(res_sel), 32'd0);
        cyc();
        reset = 1'b0;
        start = 1'b1; op_sel = 2'b00; opa = 32'h00000000; opb = 32'hFF800000;
        smp();
        cyc();
        start = 1'b0;
        smp();
        chk("post rst res_valid", 32'(res_valid), 32'd1);
        chk("post rst fast_res", fast_res, 32'h7FC00000);
        res_ready = 1'b1;
        cyc();
        res_ready = 1'b0;
        smp();
        chk("post rst idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
